// File: rtl/dmem_store_buffer.sv
// Data-memory stage: 256x16 single-port RAM fronted by an in-order store buffer.
// Optional macro SB_FORWARD_EN enables load-to-store forwarding from the buffer.
module dmem_store_buffer #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 16,
    parameter int SB_DEPTH = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          enable,
    input  logic [ADDR_W-1:0]             d_addr,
    input  logic [DATA_W-1:0]             d_dataout,
    input  logic                          d_we,
    input  logic                          d_re,
    output logic [DATA_W-1:0]             d_datain,
    output logic                          d_valid,
    output logic                          d_stall,
    output logic [$clog2(SB_DEPTH):0]     sb_count,
    output logic                          sb_empty
);

    localparam int PTR_W = $clog2(SB_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] sb_addr [SB_DEPTH];
    logic [DATA_W-1:0] sb_data [SB_DEPTH];
    logic [DATA_W-1:0] mem     [2**ADDR_W];

    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  count;

    logic              full;
    logic              addr_hit;
    logic              load_block;
    logic              store_acc;
    logic              load_acc;
    logic              drain;
`ifdef SB_FORWARD_EN
    logic [DATA_W-1:0] fwd_data;
`endif

    // Walk oldest to youngest so the last match seen is the youngest entry.
    always_comb begin
        addr_hit = 1'b0;
`ifdef SB_FORWARD_EN
        fwd_data = '0;
`endif
        for (int k = 0; k < SB_DEPTH; k++) begin
            if ((CNT_W'(k) < count) && (sb_addr[head + PTR_W'(k)] == d_addr)) begin
                addr_hit = 1'b1;
`ifdef SB_FORWARD_EN
                fwd_data = sb_data[head + PTR_W'(k)];
`endif
            end
        end
    end

    // Request handshake: a request (d_we and/or d_re) is taken at the rising
    // edge when enable=1 and d_stall=0; with d_stall=1 neither is taken and the
    // CPU must hold the request. d_stall never depends on a same-cycle drain.
    always_comb begin
        full = (count == CNT_W'(SB_DEPTH));
`ifdef SB_FORWARD_EN
        load_block = 1'b0;
`else
        load_block = d_re & addr_hit;
`endif
        d_stall   = enable & ((d_we & full) | load_block);
        store_acc = d_we & enable & ~d_stall;
        load_acc  = d_re & enable & ~d_stall;
        drain     = enable & (count != '0) & ~load_acc;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            d_datain <= '0;
            d_valid  <= 1'b0;
        end else begin
            d_valid <= load_acc;
            if (load_acc) begin
`ifdef SB_FORWARD_EN
                d_datain <= addr_hit ? fwd_data : mem[d_addr];
`else
                d_datain <= mem[d_addr];
`endif
            end
            if (store_acc) begin
                sb_addr[tail] <= d_addr;
                sb_data[tail] <= d_dataout;
                tail          <= tail + PTR_W'(1);
            end
            if (drain) begin
                head <= head + PTR_W'(1);
            end
            case ({store_acc, drain})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // The RAM port is shared: drain only writes in cycles no load is reading.
    always_ff @(posedge clock) begin
        if (!reset && drain) begin
            mem[sb_addr[head]] <= sb_data[head];
        end
    end

    assign sb_count = count;
    assign sb_empty = (count == '0);

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Bench for dmem_store_buffer: directed steps then random traffic, checked
// against a queue-plus-array reference model of the buffer and RAM.
module tb_dmem_store_buffer;

    localparam int ADDR_W   = 8;
    localparam int DATA_W   = 16;
    localparam int SB_DEPTH = 4;
`ifdef SB_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic                       clock = 1'b0;
    logic                       reset;
    logic                       enable;
    logic [ADDR_W-1:0]          d_addr;
    logic [DATA_W-1:0]          d_dataout;
    logic                       d_we;
    logic                       d_re;
    logic [DATA_W-1:0]          d_datain;
    logic                       d_valid;
    logic                       d_stall;
    logic [$clog2(SB_DEPTH):0]  sb_count;
    logic                       sb_empty;

    dmem_store_buffer #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SB_DEPTH(SB_DEPTH)
    ) dut (
        .clock(clock), .reset(reset), .enable(enable),
        .d_addr(d_addr), .d_dataout(d_dataout), .d_we(d_we), .d_re(d_re),
        .d_datain(d_datain), .d_valid(d_valid), .d_stall(d_stall),
        .sb_count(sb_count), .sb_empty(sb_empty)
    );

    always #5 clock = ~clock;

    // Reference model: pending stores oldest-first as {addr, data}, plus RAM image.
    logic [ADDR_W+DATA_W-1:0] exp_q [$];
    logic [DATA_W-1:0]        ram_m [2**ADDR_W];
    logic [DATA_W-1:0]        exp_datain;
    bit                       exp_valid;
    int                       n_vec;
    int                       n_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".d_valid"},  32'(d_valid),  32'(exp_valid));
        chk({tag, ".d_datain"}, 32'(d_datain), 32'(exp_datain));
        chk({tag, ".sb_count"}, 32'(sb_count), 32'(exp_q.size()));
        chk({tag, ".sb_empty"}, 32'(sb_empty), 32'(exp_q.size() == 0));
    endtask

    task automatic step(input string tag, input bit en, input bit we, input bit re,
                        input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] dt);
        bit                       hit;
        bit                       stall_m;
        bit                       st;
        bit                       ld;
        logic [DATA_W-1:0]        hit_d;
        logic [ADDR_W+DATA_W-1:0] head_e;
        reset = 1'b0; enable = en; d_we = we; d_re = re; d_addr = a; d_dataout = dt;
        hit = 1'b0;
        hit_d = '0;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (exp_q[i][ADDR_W+DATA_W-1:DATA_W] == a) begin
                hit = 1'b1;
                hit_d = exp_q[i][DATA_W-1:0];
            end
        end
        stall_m = en && ((we && exp_q.size() == SB_DEPTH) || (re && !FWD && hit));
        st = en && we && !stall_m;
        ld = en && re && !stall_m;
        #1;
        chk({tag, ".d_stall"}, 32'(d_stall), 32'(stall_m));
        @(posedge clock);
        exp_valid = ld;
        if (ld) exp_datain = (FWD && hit) ? hit_d : ram_m[a];
        if (en && exp_q.size() > 0 && !ld) begin
            head_e = exp_q.pop_front();
            ram_m[head_e[ADDR_W+DATA_W-1:DATA_W]] = head_e[DATA_W-1:0];
        end
        if (st) exp_q.push_back({a, dt});
        #1;
        check_outputs(tag);
    endtask

    task automatic do_reset(input bit en, input bit we, input bit re);
        reset = 1'b1; enable = en; d_we = we; d_re = re;
        d_addr = 8'h30; d_dataout = 16'h5A5A;
        @(posedge clock);
        exp_q.delete();
        exp_valid = 1'b0;
        exp_datain = '0;
        #1;
        check_outputs("reset");
        reset = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step("idle", 1'b1, 1'b0, 1'b0, 8'h00, 16'h0000);
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        reset = 1'b1; enable = 1'b0; d_we = 1'b0; d_re = 1'b0;
        d_addr = '0; d_dataout = '0;
        exp_valid = 1'b0; exp_datain = '0;
        @(posedge clock); #1;
        do_reset(1'b1, 1'b1, 1'b1);

        // Fill the whole RAM with 0xFFFF so every later read is known.
        for (int i = 0; i < 2**ADDR_W; i++) step("prefill", 1'b1, 1'b1, 1'b0, 8'(i), 16'hFFFF);
        idle(3);

        // Store then immediate load of the same address.
        step("st34", 1'b1, 1'b1, 1'b0, 8'h34, 16'hABCD);
        step("ld34a", 1'b1, 1'b0, 1'b1, 8'h34, 16'h0000);
        step("ld34b", 1'b1, 1'b0, 1'b1, 8'h34, 16'h0000);
        idle(2);

        // Youngest of three stores to one address wins.
        step("st10a", 1'b1, 1'b1, 1'b0, 8'h10, 16'h1111);
        step("st10b", 1'b1, 1'b1, 1'b0, 8'h10, 16'h2222);
        step("st10c", 1'b1, 1'b1, 1'b0, 8'h10, 16'h3333);
        step("ld10a", 1'b1, 1'b0, 1'b1, 8'h10, 16'h0000);
        step("ld10b", 1'b1, 1'b0, 1'b1, 8'h10, 16'h0000);
        idle(5);
        step("ld10ram", 1'b1, 1'b0, 1'b1, 8'h10, 16'h0000);
        idle(1);

        // Loads hold the port so stores pile up until the buffer is full.
        for (int i = 0; i < 5; i++) step("fill", 1'b1, 1'b1, 1'b1, 8'h20 + 8'(i), 16'h2000 + 16'(i));
        step("st24retry", 1'b1, 1'b1, 1'b0, 8'h24, 16'h2004);
        idle(6);
        for (int i = 0; i < 5; i++) step("ld2x", 1'b1, 1'b0, 1'b1, 8'h20 + 8'(i), 16'h0000);

        // Buffered stores drain in order while idle.
        for (int i = 1; i <= 4; i++) step("fill01", 1'b1, 1'b1, 1'b1, 8'(i), 16'h0100 + 16'(i));
        idle(5);
        for (int i = 1; i <= 4; i++) step("ld0x", 1'b1, 1'b0, 1'b1, 8'(i), 16'h0000);

        // Reset discards buffered stores; RAM keeps 0xFFFF.
        for (int i = 0; i < 3; i++) step("pre_rst", 1'b1, 1'b1, 1'b1, 8'h40 + 8'(i), 16'h4000 + 16'(i));
        do_reset(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step("ld4x", 1'b1, 1'b0, 1'b1, 8'h40 + 8'(i), 16'h0000);

        // enable low freezes everything.
        for (int i = 0; i < 2; i++) step("pre_frz", 1'b1, 1'b1, 1'b1, 8'h50 + 8'(i), 16'h5000 + 16'(i));
        for (int i = 0; i < 5; i++) step("frozen", 1'b0, 1'(i % 2), 1'(1 - i % 2), 8'h50, 16'hDEAD);
        idle(3);
        step("ld50", 1'b1, 1'b0, 1'b1, 8'h50, 16'h0000);
        step("ld51", 1'b1, 1'b0, 1'b1, 8'h51, 16'h0000);

        // Random traffic over a narrow address window to force matches and fills.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 63) == 0) begin
                do_reset(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end else begin
                step("rand", $urandom_range(0, 9) != 0, 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 8'h30 + 8'($urandom_range(0, 5)), 16'($urandom));
            end
        end
        idle(6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dmem_store_buffer.md
Name: dmem_store_buffer

Overview:
- Data-memory stage directly downstream of the CPU's data port.
- Consumes the CPU's d_addr, d_dataout and d_we, plus a load strobe; returns d_datain.
- Contains a 256x16 single-port data RAM and a small in-order store buffer, so stores retire in one cycle.
- Loads see the youngest buffered data by forwarding; sb_empty lets the CPU confirm all stores are committed before HALT.

Parameters:
- ADDR_W, 8, address width; RAM holds 2**ADDR_W words.
- DATA_W, 16, data word width.
- SB_DEPTH, 4, store-buffer entries; power of two, at least 2.

Ports:
- clock  in  1  single system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high.
- enable  in  1  run gate; when low the block freezes.
- d_addr  in  ADDR_W  load/store address from the CPU.
- d_dataout  in  DATA_W  store data from the CPU.
- d_we  in  1  store request.
- d_re  in  1  load request.
- d_datain  out  DATA_W  load result to the CPU; registered.
- d_valid  out  1  one-cycle pulse; d_datain is valid.
- d_stall  out  1  combinational; the current request is not accepted and the CPU holds it.
- sb_count  out  $clog2(SB_DEPTH)+1  number of occupied buffer entries.
- sb_empty  out  1  high when sb_count is 0.

Behaviour:
- Reset (synchronous, high at an edge):
  - Buffer pointers and count go to 0; pending stores are discarded.
  - d_datain=0, d_valid=0, sb_empty=1.
  - RAM contents are not reset.
  - Reset overrides enable and any request in the same cycle.
- Store accept: d_we & enable & ~d_stall pushes {d_addr, d_dataout} at the tail.
  - A full buffer gives d_stall=1 whenever d_we=1.
  - This holds even if a drain happens in the same cycle; the rule is conservative and contains no full-bypass path.
- Drain: every cycle with enable=1, buffer non-empty and no accepted load, the head entry is written to RAM and popped.
  - Drain order is strictly FIFO.
  - A load owns the RAM port and takes priority; the drain waits that cycle.
- Load accept: d_re & enable & ~d_stall.
  - At edge N+1: d_valid=1, and d_datain = data from the youngest buffer entry matching d_addr, else RAM[d_addr].
  - Latency is exactly 1 cycle.
  - Forwarding searches only entries present before edge N; a store pushed at the same edge is not visible to that load.
- Simultaneous d_we & d_re: both are accepted if neither stalls. The load returns the pre-store value, and no drain occurs that cycle.
- Push and pop in the same cycle: count is unchanged and pointers wrap modulo SB_DEPTH.
- d_valid is 0 in every cycle without a just-accepted load. d_datain holds its last value otherwise.
- enable=0: no push, no pop, no load; d_valid=0; all state held; d_stall=0.
- sb_count and sb_empty are registered-state derived and update at the edge after a push or pop.

Optional Feature:
- Macro SB_FORWARD_EN.
- Defined: load-to-store forwarding as described under Behaviour.
- Not defined:
  - No forwarding path.
  - A load whose address matches any buffer entry gets d_stall=1 and is not accepted.
  - Drain continues on those cycles because no load owns the port.
  - The load is accepted once no entry matches; it then returns RAM data.
  - A load with no match is accepted normally.

Test Plan:
- Reset, then store 16'hABCD at 0x34 and load 0x34 in the next cycle -> with SB_FORWARD_EN, d_valid=1 and d_datain=ABCD one cycle later. Without it, d_stall=1 for 1 cycle, then ABCD is read from RAM.
- Stores 0x1111, 0x2222, 0x3333 all to 0x10 back-to-back, then load 0x10 -> 0x3333 (youngest). After idle, sb_empty=1 and a RAM read of 0x10 returns 0x3333.
- Hold d_re=1 to 0x00 every cycle while issuing 5 stores to 0x20-0x24 -> first 4 accepted and sb_count=4; 5th gives d_stall=1. Drop d_re -> one drain, and the 5th store is accepted next cycle.
- Stores to 0x01..0x04, then idle with d_re=0 -> drains over 4 cycles in address order; sb_count 4,3,2,1,0; a load of each address returns its data.
- 3 stores buffered, assert reset for 1 cycle -> sb_count=0, d_valid=0, d_datain=0. A subsequent load of those addresses does not return the discarded data; RAM was pre-written with 0xFFFF and must still read 0xFFFF.
- enable=0 for 5 cycles with 2 entries buffered and d_we/d_re pulsed -> sb_count stays 2, d_valid=0, d_stall=0. Raise enable -> drain resumes.
